// File: rtl/blake2b_pkg.sv
// Shared constants and helpers for the BLAKE2b compression sequencer and its G-function lanes.
package blake2b_pkg;

    localparam int NW_H = 8;
    localparam int NW_M = 16;

    typedef enum logic [2:0] {IDLE, ISSUE, WB, FINAL, DONE} stateT;

    localparam logic [63:0] IV [NW_H] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [3:0] SIGMA [10][16] = '{
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hb, 4'hc, 4'hd, 4'he, 4'hf},
        '{4'he, 4'ha, 4'h4, 4'h8, 4'h9, 4'hf, 4'hd, 4'h6, 4'h1, 4'hc, 4'h0, 4'h2, 4'hb, 4'h7, 4'h5, 4'h3},
        '{4'hb, 4'h8, 4'hc, 4'h0, 4'h5, 4'h2, 4'hf, 4'hd, 4'ha, 4'he, 4'h3, 4'h6, 4'h7, 4'h1, 4'h9, 4'h4},
        '{4'h7, 4'h9, 4'h3, 4'h1, 4'hd, 4'hc, 4'hb, 4'he, 4'h2, 4'h6, 4'h5, 4'ha, 4'h4, 4'h0, 4'hf, 4'h8},
        '{4'h9, 4'h0, 4'h5, 4'h7, 4'h2, 4'h4, 4'ha, 4'hf, 4'he, 4'h1, 4'hb, 4'hc, 4'h6, 4'h8, 4'h3, 4'hd},
        '{4'h2, 4'hc, 4'h6, 4'ha, 4'h0, 4'hb, 4'h8, 4'h3, 4'h4, 4'hd, 4'h7, 4'h5, 4'hf, 4'he, 4'h1, 4'h9},
        '{4'hc, 4'h5, 4'h1, 4'hf, 4'he, 4'hd, 4'h4, 4'ha, 4'h0, 4'h7, 4'h6, 4'h3, 4'h9, 4'h2, 4'h8, 4'hb},
        '{4'hd, 4'hb, 4'h7, 4'he, 4'hc, 4'h1, 4'h3, 4'h9, 4'h5, 4'h0, 4'hf, 4'h4, 4'h8, 4'h6, 4'h2, 4'ha},
        '{4'h6, 4'hf, 4'he, 4'h9, 4'hb, 4'h3, 4'h0, 4'h8, 4'hc, 4'h2, 4'hd, 4'h7, 4'h1, 4'h4, 4'ha, 4'h5},
        '{4'ha, 4'h2, 4'h8, 4'h4, 4'h7, 4'h6, 4'h1, 4'h5, 4'hf, 4'hb, 4'h9, 4'he, 4'h3, 4'hc, 4'hd, 4'h0}
    };

    function automatic logic [63:0] rotr64(input logic [63:0] w, input int unsigned n);
        return (w >> n) | (w << (64 - n));
    endfunction

    // v index for operand pos (0=a..3=d) of lane g; diagonal steps rotate the lane by pos.
    function automatic logic [3:0] gIdx(input logic half, input logic [1:0] g, input logic [1:0] pos);
        logic [1:0] lane;
        lane = half ? 2'(g + pos) : g;
        return {pos, lane};
    endfunction

    function automatic logic [3:0] sigmaSel(input logic [3:0] row, input logic [3:0] k);
        return SIGMA[row][k];
    endfunction

endpackage

// File: rtl/blake2b_compress_if.sv
// Block-in / chaining-value-out handshake bundle of the compression sequencer.
interface blake2b_compress_if;
    import blake2b_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [64*NW_H-1:0]     h_in;
    logic [64*NW_M-1:0]     m_in;
    logic [127:0]           t_in;
    logic                   last_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [64*NW_H-1:0]     h_out;

    modport master (
        output in_valid, h_in, m_in, t_in, last_in, out_ready,
        input  in_ready, out_valid, h_out
    );

    modport slave (
        input  in_valid, h_in, m_in, t_in, last_in, out_ready,
        output in_ready, out_valid, h_out
    );

endinterface

// File: rtl/mix.sv
// BLAKE2b G function with registered outputs; one full G (both half-steps) per clock.
module mix
    import blake2b_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] c,
    input  logic [63:0] d,
    input  logic [63:0] x,
    input  logic [63:0] y,
    output logic [63:0] aOut,
    output logic [63:0] bOut,
    output logic [63:0] cOut,
    output logic [63:0] dOut
);

    logic [63:0] a1, b1, c1, d1, a2, b2, c2, d2;

    always_comb begin
        a1 = a + b + x;
        d1 = rotr64(d ^ a1, 32);
        c1 = c + d1;
        b1 = rotr64(b ^ c1, 24);
        a2 = a1 + b1 + y;
        d2 = rotr64(d1 ^ a2, 16);
        c2 = c1 + d2;
        b2 = rotr64(b1 ^ c2, 63);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aOut <= '0;
            bOut <= '0;
            cOut <= '0;
            dOut <= '0;
        end else begin
            aOut <= a2;
            bOut <= b2;
            cOut <= c2;
            dOut <= d2;
        end
    end

endmodule

// File: rtl/blake2b_compress.sv
// BLAKE2b compression-round sequencer: four G lanes, one half-round per ISSUE/WB pair.
module blake2b_compress
    import blake2b_pkg::*;
#(
    parameter int ROUNDS = 12
)(
    input  logic                clk,
    input  logic                rst,
    blake2b_compress_if.slave   bus
);

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    stateT              state;
    logic               inReady;
    logic               outValid;
    logic [64*NW_H-1:0] hOut;
    logic [7:0]         round;
    logic               half;

    logic [63:0] vReg [16];
    logic [63:0] hReg [NW_H];
    logic [63:0] mReg [NW_M];
    logic [63:0] tweak [NW_H];

    logic [63:0] mixA [4], mixB [4], mixC [4], mixD [4], mixX [4], mixY [4];
    logic [63:0] outA [4], outB [4], outC [4], outD [4];

    logic [3:0] sigmaRow;
    logic       accept;

    assign accept   = bus.in_valid & inReady & (state == IDLE);
    assign sigmaRow = 4'(round % 8'd10);

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.h_out     = hOut;

    // Counter and finalisation flag folded into the upper IV half of v.
    always_comb begin
        for (int i = 0; i < NW_H; i++) tweak[i] = '0;
        tweak[4] = bus.t_in[63:0];
        tweak[5] = bus.t_in[127:64];
        tweak[6] = {64{bus.last_in}};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            localparam logic [1:0] LANE = 2'(gi);

            assign mixA[gi] = vReg[gIdx(half, LANE, 2'd0)];
            assign mixB[gi] = vReg[gIdx(half, LANE, 2'd1)];
            assign mixC[gi] = vReg[gIdx(half, LANE, 2'd2)];
            assign mixD[gi] = vReg[gIdx(half, LANE, 2'd3)];
            assign mixX[gi] = mReg[sigmaSel(sigmaRow, {half, LANE, 1'b0})];
            assign mixY[gi] = mReg[sigmaSel(sigmaRow, {half, LANE, 1'b1})];

            mix uMix (
                .clk  (clk),
                .rst  (rst),
                .a    (mixA[gi]),
                .b    (mixB[gi]),
                .c    (mixC[gi]),
                .d    (mixD[gi]),
                .x    (mixX[gi]),
                .y    (mixY[gi]),
                .aOut (outA[gi]),
                .bOut (outB[gi]),
                .cOut (outC[gi]),
                .dOut (outD[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inReady  <= 1'b0;
            outValid <= 1'b0;
            hOut     <= '0;
            round    <= '0;
            half     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    inReady <= ~accept;
                    if (accept) begin
                        round <= '0;
                        half  <= 1'b0;
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WB;
                WB: begin
                    half <= ~half;
                    if (half) round <= round + 8'd1;
                    state <= (half && round == LAST_ROUND) ? FINAL : ISSUE;
                end
                FINAL: begin
                    for (int i = 0; i < NW_H; i++)
                        hOut[64*i +: 64] <= hReg[i] ^ vReg[i] ^ vReg[i+NW_H];
                    outValid <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working state carries no reset; an aborted block is simply overwritten by the next load.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NW_H; i++) begin
                hReg[i]      <= bus.h_in[64*i +: 64];
                vReg[i]      <= bus.h_in[64*i +: 64];
                vReg[NW_H+i] <= IV[i] ^ tweak[i];
            end
            for (int i = 0; i < NW_M; i++)
                mReg[i] <= bus.m_in[64*i +: 64];
        end else if (state == WB) begin
            for (int g = 0; g < 4; g++) begin
                vReg[gIdx(half, 2'(g), 2'd0)] <= outA[g];
                vReg[gIdx(half, 2'(g), 2'd1)] <= outB[g];
                vReg[gIdx(half, 2'(g), 2'd2)] <= outC[g];
                vReg[gIdx(half, 2'(g), 2'd3)] <= outD[g];
            end
        end
    end

endmodule
